// File: rtl/mux2to1_trio_if.sv
// Bundle for mux2to1_trio: packed input lanes, lane select and the four result views.
// The master drives in_d/sel; the slave (the mux) drives the results and the flag.
interface mux2to1_trio_if #(
    parameter int unsigned WIDTH = 1
);

    logic [2*WIDTH-1:0] in_d;
    logic               sel;
    logic [WIDTH-1:0]   out_d;
    logic [WIDTH-1:0]   out_s;
    logic [WIDTH-1:0]   out_b;
    logic [WIDTH-1:0]   out_q;
    logic               mismatch;

    modport master (
        output in_d,
        output sel,
        input  out_d,
        input  out_s,
        input  out_b,
        input  out_q,
        input  mismatch
    );

    modport slave (
        input  in_d,
        input  sel,
        output out_d,
        output out_s,
        output out_b,
        output out_q,
        output mismatch
    );

endinterface

// File: rtl/mux2to1_trio.sv
// 2:1 lane select built three ways (dataflow, gate-level, procedural), plus a registered
// copy of the result and a sticky flag raised whenever the three versions disagree.
module mux2to1_trio #(
    parameter int unsigned WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux2to1_trio_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("mux2to1_trio: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;

    assign lane0 = bus.in_d[WIDTH-1:0];
    assign lane1 = bus.in_d[2*WIDTH-1:WIDTH];

    // Dataflow view.
    assign bus.out_d = bus.sel ? lane1 : lane0;

    // Gate-level view: one shared inverter, then AND/AND/OR per bit.
    wire              sel_n;
    wire [WIDTH-1:0]  and0;
    wire [WIDTH-1:0]  and1;
    wire [WIDTH-1:0]  gate_res;

    not u_sel_inv (sel_n, bus.sel);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and u_and0 (and0[i], lane0[i], sel_n);
        and u_and1 (and1[i], lane1[i], bus.sel);
        or  u_or   (gate_res[i], and0[i], and1[i]);
    end

    assign bus.out_s = gate_res;

    // Procedural view.
    logic [WIDTH-1:0] beh_res;

    always_comb begin
        beh_res = '0;
        if (bus.sel) begin
            beh_res = lane1;
        end else begin
            beh_res = lane0;
        end
    end

    assign bus.out_b = beh_res;

    // Registered result and sticky cross-check. The compare reads the outputs as seen on
    // the bus so any disturbance of a published result is caught.
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             mismatch_d;
    logic             mismatch_q;

    always_comb begin
        res_d      = bus.out_b;
        mismatch_d = mismatch_q
                   | (bus.out_d != bus.out_s)
                   | (bus.out_d != bus.out_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            res_q      <= res_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.out_q    = res_q;
    assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_mux2to1_trio.sv
// Directed, table-driven bench for mux2to1_trio at WIDTH=1 and WIDTH=8.
module tb_mux2to1_trio;

    logic clk;
    logic rst;

    mux2to1_trio_if #(.WIDTH(1)) u_if1 ();
    mux2to1_trio_if #(.WIDTH(8)) u_if8 ();

    mux2to1_trio #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.slave)
    );

    mux2to1_trio #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (u_if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] in_d;
        logic        sel;
        logic [7:0]  exp;
        bit          wide;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] prev1;
        logic [7:0] prev8;

        // WIDTH=1 truth table: f = sel ? in_d[1] : in_d[0]
        vecs[0]  = '{16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{16'h0000, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{16'h0001, 1'b0, 8'h01, 1'b0};
        vecs[3]  = '{16'h0001, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{16'h0002, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{16'h0002, 1'b1, 8'h01, 1'b0};
        vecs[6]  = '{16'h0003, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{16'h0003, 1'b1, 8'h01, 1'b0};
        // WIDTH=8 lanes
        vecs[8]  = '{16'hA53C, 1'b0, 8'h3C, 1'b1};
        vecs[9]  = '{16'hA53C, 1'b1, 8'hA5, 1'b1};
        vecs[10] = '{16'hFF00, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{16'hFF00, 1'b1, 8'hFF, 1'b1};
        vecs[12] = '{16'h1234, 1'b1, 8'h12, 1'b1};

        // Reset with WIDTH=1 in_d=10, sel=0
        rst = 1'b0;
        u_if1.in_d = 2'b10;
        u_if1.sel  = 1'b0;
        u_if8.in_d = 16'hA53C;
        u_if8.sel  = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_d", 64'(u_if1.out_d), 64'h0);
        check("rst_out_s", 64'(u_if1.out_s), 64'h0);
        check("rst_out_b", 64'(u_if1.out_b), 64'h0);
        check("rst_out_q", 64'(u_if1.out_q), 64'h0);
        check("rst_mismatch", 64'(u_if1.mismatch), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("post_rst_out_q", 64'(u_if1.out_q), 64'h0);
        check("post_rst_mismatch", 64'(u_if1.mismatch), 64'h0);

        // sel 0->1 propagates without a clock
        @(negedge clk) u_if1.sel = 1'b1;
        #1;
        check("sel_out_d", 64'(u_if1.out_d), 64'h1);
        check("sel_out_s", 64'(u_if1.out_s), 64'h1);
        check("sel_out_b", 64'(u_if1.out_b), 64'h1);
        check("sel_out_q_hold", 64'(u_if1.out_q), 64'h0);
        @(posedge clk) #1;
        check("sel_out_q", 64'(u_if1.out_q), 64'h1);
        check("sel_mismatch", 64'(u_if1.mismatch), 64'h0);

        // Table sweep
        prev1 = 8'h01;
        prev8 = 8'h3C;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (vecs[i].wide) begin
                u_if8.in_d = vecs[i].in_d;
                u_if8.sel  = vecs[i].sel;
                #1;
                check($sformatf("v%0d_out_d", i), 64'(u_if8.out_d), 64'(vecs[i].exp));
                check($sformatf("v%0d_out_s", i), 64'(u_if8.out_s), 64'(vecs[i].exp));
                check($sformatf("v%0d_out_b", i), 64'(u_if8.out_b), 64'(vecs[i].exp));
                check($sformatf("v%0d_q_lag", i), 64'(u_if8.out_q), 64'(prev8));
                @(posedge clk) #1;
                check($sformatf("v%0d_out_q", i), 64'(u_if8.out_q), 64'(vecs[i].exp));
                prev8 = vecs[i].exp;
            end else begin
                u_if1.in_d = vecs[i].in_d[1:0];
                u_if1.sel  = vecs[i].sel;
                #1;
                check($sformatf("v%0d_out_d", i), 64'(u_if1.out_d), 64'(vecs[i].exp));
                check($sformatf("v%0d_out_s", i), 64'(u_if1.out_s), 64'(vecs[i].exp));
                check($sformatf("v%0d_out_b", i), 64'(u_if1.out_b), 64'(vecs[i].exp));
                check($sformatf("v%0d_q_lag", i), 64'(u_if1.out_q), 64'(prev1));
                @(posedge clk) #1;
                check($sformatf("v%0d_out_q", i), 64'(u_if1.out_q), 64'(vecs[i].exp));
                prev1 = vecs[i].exp;
            end
        end
        check("sweep_mismatch_w1", 64'(u_if1.mismatch), 64'h0);
        check("sweep_mismatch_w8", 64'(u_if8.mismatch), 64'h0);

        // Asynchronous reset between edges
        @(negedge clk);
        u_if8.in_d = 16'hA53C;
        u_if8.sel  = 1'b1;
        @(posedge clk) #1;
        check("pre_async_out_q", 64'(u_if8.out_q), 64'hA5);
        @(negedge clk) #1 rst = 1'b1;
        #1;
        check("async_out_q", 64'(u_if8.out_q), 64'h0);
        check("async_mismatch", 64'(u_if8.mismatch), 64'h0);
        check("async_comb_live", 64'(u_if8.out_d), 64'hA5);
        #1 rst = 1'b0;
        @(posedge clk) #1;
        check("async_restore_q", 64'(u_if8.out_q), 64'hA5);

        // Forced disagreement on the gate-level result
        @(negedge clk) force u_if8.out_s = 8'h00;
        @(posedge clk) #1;
        check("force_mismatch", 64'(u_if8.mismatch), 64'h1);
        @(negedge clk) release u_if8.out_s;
        #1;
        check("force_released_s", 64'(u_if8.out_s), 64'hA5);
        @(posedge clk) #1;
        check("sticky_mismatch", 64'(u_if8.mismatch), 64'h1);
        check("other_dut_clean", 64'(u_if1.mismatch), 64'h0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mismatch_cleared", 64'(u_if8.mismatch), 64'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("mismatch_stays_clear", 64'(u_if8.mismatch), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux2to1_trio.md
Name: mux2to1_trio

Overview:
- 2:1 multiplexer block that builds the same select function three ways:
  - dataflow: continuous conditional assignment;
  - structural: gate primitives NOT/AND/OR per bit;
  - behavioural: combinational procedural block.
- The three combinational results are exposed individually.
- A registered copy of the result and a sticky cross-check flag are also provided.
- Used as a datapath select primitive and as a self-checking reference for equivalence between coding styles.

Parameters:
- WIDTH, 1, bit width of each data lane; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_d  input  2*WIDTH  packed data.
  - Lane 0 = in_d[WIDTH-1:0].
  - Lane 1 = in_d[2*WIDTH-1:WIDTH].
- sel  input  1  lane select: 0 selects lane 0, 1 selects lane 1.
- out_d  output  WIDTH  dataflow result, combinational.
- out_s  output  WIDTH  structural (gate-level) result, combinational.
- out_b  output  WIDTH  behavioural result, combinational.
- out_q  output  WIDTH  registered result.
- mismatch  output  1  sticky flag: the three combinational results have disagreed.

Behaviour:
- Combinational paths (out_d, out_s, out_b):
  - Zero latency and independent of clk and rst.
  - sel=0 -> lane 0.
  - sel=1 -> lane 1.
- out_d: single conditional expression on sel.
- out_s:
  - Per bit i, out_s[i] = (lane0[i] AND NOT sel) OR (lane1[i] AND sel).
  - Built from gate primitives in a generate loop.
  - One shared inverter on sel.
- out_b:
  - Combinational procedural block with full sensitivity.
  - if/else on sel; default assignment first so no latch is inferred.
- out_q:
  - On each rising clk, out_q <= out_b.
  - Latency is exactly 1 cycle from a stable in_d/sel.
- mismatch:
  - On each rising clk, mismatch <= mismatch OR (out_d != out_s) OR (out_d != out_b).
  - Once set, stays 1 until reset.
- Reset:
  - While rst=1: out_q=0 and mismatch=0, taking effect immediately without a clock.
  - Combinational outputs keep following inputs during reset.
- Reset release: the first rising clk with rst=0 captures normally.
- Reset mid-operation: clears out_q and mismatch asynchronously; no other state exists.
- Simultaneous sel and data change: all combinational outputs reflect the new values after propagation. out_q reflects them at the next edge.
- Unknown sel (X/Z): not a supported operating condition.
  - Outputs are unspecified in that case.
  - The mismatch flag is not required to stay clear.
- No enable, no handshake, no backpressure.

Test Plan:
- WIDTH=1, apply rst=1, then in_d=2'b10, sel=0 -> out_d=out_s=out_b=0; after rst=0 and one clk, out_q=0, mismatch=0.
- WIDTH=1, in_d=2'b10, then sel switches 0->1 -> all combinational outputs go to 1 with no clock; out_q=1 after the next rising clk; mismatch stays 0.
- WIDTH=1, exhaustive sweep of all 8 combinations of in_d and sel, one clk each -> every output matches the truth table (f = sel ? in_d[1] : in_d[0]); out_q lags by 1 cycle; mismatch=0 at the end.
- WIDTH=8, in_d={8'hA5,8'h3C}, sel=0 then 1 -> outputs 8'h3C, then 8'hA5; out_q follows one cycle later.
- Asynchronous reset mid-run: out_q=8'hA5, assert rst between clock edges -> out_q=0 and mismatch=0 immediately; deassert rst, next clk -> out_q restores to the selected lane.
- Forced mismatch: force out_s to disagree with the other two results for one edge -> mismatch=1 and stays 1 after the force is released, until rst is asserted.
